// File: rtl/cnn_sched_pkg.sv
// cnn_sched_pkg: shared types and sizes for the conv tile scheduler.
// Geometry bounds, derived index widths, K-group size and FSM states.
package cnn_sched_pkg;

    localparam int CHUNK_K = 8;
    localparam int PACK    = 4;
    localparam int MAX_X1  = 5;
    localparam int MAX_X2  = 5;
    localparam int MAX_X3  = 32;
    localparam int MAX_Y1  = 32;
    localparam int MAX_Y2  = 32;
    localparam int MAX_N   = 64;

    localparam int X1W = $clog2(MAX_X1) + 1;
    localparam int X2W = $clog2(MAX_X2) + 1;
    localparam int X3W = $clog2(MAX_X3) + 1;
    localparam int Y1W = $clog2(MAX_Y1) + 1;
    localparam int Y2W = $clog2(MAX_Y2) + 1;
    localparam int NW  = $clog2(MAX_N) + 1;

    // Elements consumed per K-group; must be a power of two.
    localparam int GRP_ELEMS = CHUNK_K * PACK;
    localparam int GRP_LOG2  = $clog2(GRP_ELEMS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_RUN,
        S_GAP,
        S_RES,
        S_FIN
    } state_t;

endpackage

// File: rtl/conv_dim_calc.sv
// conv_dim_calc: output dimension (y-x)/stride+1 by repeated subtraction.
// start loads operands; ready rises once the quotient is final.
module conv_dim_calc #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] y,
    input  logic [W-1:0] x,
    input  logic [2:0]   stride,
    output logic         ready,
    output logic [W-1:0] dim
);

    logic [W-1:0] rem;
    logic [W-1:0] cnt;
    logic [2:0]   stp;
    logic         run;

    // Subtract one stride per cycle until the remainder is smaller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            cnt   <= '0;
            stp   <= '0;
            run   <= 1'b0;
            ready <= 1'b0;
        end else if (start) begin
            rem   <= y - x;
            cnt   <= '0;
            stp   <= stride;
            run   <= 1'b1;
            ready <= 1'b0;
        end else if (run) begin
            if (rem >= W'(stp)) begin
                rem <= rem - W'(stp);
                cnt <= cnt + W'(1);
            end else begin
                run   <= 1'b0;
                ready <= 1'b1;
            end
        end
    end

    assign dim = cnt + W'(1);

endmodule

// File: rtl/conv_tile_sched.sv
// conv_tile_sched: walks n / patch_i / patch_j / k_grp for im2col.
// Define CNN_SCHED_PERF_EN to add perf_cycles and perf_stall counters.
module conv_tile_sched
    import cnn_sched_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [X1W-1:0] X1,
    input  logic [X2W-1:0] X2,
    input  logic [X3W-1:0] X3,
    input  logic [Y1W-1:0] Y1,
    input  logic [Y2W-1:0] Y2,
    input  logic [NW-1:0]  N_OUT,
    input  logic [2:0]     STRIDE,
    input  logic           im2_done,
    output logic           en_im2,
    output logic [Y2W-1:0] patch_i,
    output logic [Y1W-1:0] patch_j,
    output logic [15:0]    n,
    output logic [15:0]    k_grp,
    output logic           acc_clr,
    output logic           acc_last,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy,
    output logic           done,
`ifdef CNN_SCHED_PERF_EN
    output logic [31:0]    perf_cycles,
    output logic [31:0]    perf_stall,
`endif
    output logic           err
);

    state_t         state;
    state_t         state_nx;
    logic [NW-1:0]  n_out;
    logic [15:0]    ngrp;
    logic [15:0]    prod;
    logic           first;
    logic           bad;
    logic           go;
    logic           div_go;
    logic           ow_rdy;
    logic           oh_rdy;
    logic [Y1W-1:0] ow;
    logic [Y2W-1:0] oh;
    logic           last_k;
    logic           last_j;
    logic           last_i;
    logic           last_n;
    logic           accept;

    assign bad = (STRIDE == 3'd0) || (Y1 < Y1W'(X1)) ||
                 (Y2 < Y2W'(X2)) || (N_OUT == '0);
    assign go     = (state == S_IDLE) && start;
    assign div_go = go && !bad;
    assign prod   = 16'(X1) * 16'(X2) * 16'(X3);

    assign last_k = (k_grp + 16'd1) >= ngrp;
    assign last_j = (patch_j == ow - Y1W'(1));
    assign last_i = (patch_i == oh - Y2W'(1));
    assign last_n = (n == 16'(n_out) - 16'd1);
    assign accept = (state == S_RES) && res_ready;

    conv_dim_calc #(.W(Y1W)) u_ow (
        .clk    (clk),
        .rst    (rst),
        .start  (div_go),
        .y      (Y1),
        .x      (Y1W'(X1)),
        .stride (STRIDE),
        .ready  (ow_rdy),
        .dim    (ow)
    );

    conv_dim_calc #(.W(Y2W)) u_oh (
        .clk    (clk),
        .rst    (rst),
        .start  (div_go),
        .y      (Y2),
        .x      (Y2W'(X2)),
        .stride (STRIDE),
        .ready  (oh_rdy),
        .dim    (oh)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nx  = state;
        en_im2    = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nx = bad ? S_FIN : S_CALC;
            S_CALC: if (ow_rdy && oh_rdy) state_nx = S_RUN;
            S_RUN: begin
                en_im2 = 1'b1;
                if (im2_done) state_nx = S_GAP;
            end
            S_GAP: state_nx = last_k ? S_RES : S_RUN;
            S_RES: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nx = (last_j && last_i && last_n) ? S_FIN : S_RUN;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        busy     = (state != S_IDLE);
        acc_clr  = en_im2 && first;
        acc_last = en_im2 && last_k;
    end

    // Config latch, error flag and loop-nest counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_out   <= '0;
            ngrp    <= '0;
            err     <= 1'b0;
            first   <= 1'b0;
            k_grp   <= '0;
            patch_i <= '0;
            patch_j <= '0;
            n       <= '0;
        end else begin
            // First RUN cycle of a pixel: entered from CALC or RES.
            first <= (state_nx == S_RUN) && (state != S_RUN) &&
                     (state != S_GAP);
            if (go) begin
                n_out   <= N_OUT;
                ngrp    <= (prod + 16'(GRP_ELEMS - 1)) >> GRP_LOG2;
                err     <= bad;
                k_grp   <= '0;
                patch_i <= '0;
                patch_j <= '0;
                n       <= '0;
            end else if (state == S_GAP && !last_k) begin
                k_grp <= k_grp + 16'd1;
            end else if (accept) begin
                k_grp   <= '0;
                patch_j <= last_j ? '0 : patch_j + Y1W'(1);
                if (last_j) begin
                    patch_i <= last_i ? '0 : patch_i + Y2W'(1);
                    if (last_i) n <= last_n ? '0 : n + 16'd1;
                end
            end
        end
    end

`ifdef CNN_SCHED_PERF_EN
    // Busy-cycle and writeback-stall counters, cleared per layer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (go) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy) perf_cycles <= perf_cycles + 32'd1;
            if (state == S_RES && !res_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_tile_sched.sv
// tb_conv_tile_sched: table of layer configs, scoreboarded results.
// Emulates the im2col generator and a stalling writeback sink.
module tb_conv_tile_sched;
    import cnn_sched_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [X1W-1:0] X1 = '0;
    logic [X2W-1:0] X2 = '0;
    logic [X3W-1:0] X3 = '0;
    logic [Y1W-1:0] Y1 = '0;
    logic [Y2W-1:0] Y2 = '0;
    logic [NW-1:0]  N_OUT = '0;
    logic [2:0]     STRIDE = '0;
    logic           im2_done = 1'b0;
    logic           res_ready = 1'b1;
    logic           en_im2;
    logic [Y2W-1:0] patch_i;
    logic [Y1W-1:0] patch_j;
    logic [15:0]    n;
    logic [15:0]    k_grp;
    logic           acc_clr;
    logic           acc_last;
    logic           res_valid;
    logic           busy;
    logic           done;
    logic           err;
`ifdef CNN_SCHED_PERF_EN
    logic [31:0]    perf_cycles;
    logic [31:0]    perf_stall;
`endif

    always #5 clk = ~clk;

    conv_tile_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X1        (X1),
        .X2        (X2),
        .X3        (X3),
        .Y1        (Y1),
        .Y2        (Y2),
        .N_OUT     (N_OUT),
        .STRIDE    (STRIDE),
        .im2_done  (im2_done),
        .en_im2    (en_im2),
        .patch_i   (patch_i),
        .patch_j   (patch_j),
        .n         (n),
        .k_grp     (k_grp),
        .acc_clr   (acc_clr),
        .acc_last  (acc_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
`ifdef CNN_SCHED_PERF_EN
        .perf_cycles (perf_cycles),
        .perf_stall  (perf_stall),
`endif
        .err       (err)
    );

    typedef struct {
        int x1, x2, x3, y1, y2, s, nout;
        int ow, oh, ngrp, err, stall_at;
    } vec_t;

    typedef struct {
        int n, i, j;
    } pix_t;

    pix_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   ngrp_m = 0;
    int   exp_kg = 0;
    bit   pix_new = 1'b1;
    int   gap_len = 0;
    int   grp_pix = 0;
    int   total_grp = 0;
    int   accepted = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    int   run_cnt = 0;
    int   stall_at = -1;
    int   stall_left = 0;
    int   stall_seen = 0;
    bit   prev_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Generator/sink emulation plus per-cycle output checks.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            im2_done = en_im2 && (run_cnt == 1);
            run_cnt  = en_im2 ? run_cnt + 1 : 0;
            if (res_valid && accepted == stall_at && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else begin
                res_ready = 1'b1;
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (en_im2) begin
                if (!prev_en) begin
                    if (pix_new) begin
                        exp_kg  = 0;
                        pix_new = 1'b0;
                    end else begin
                        chk("gap_len", gap_len, 1);
                        exp_kg++;
                    end
                    grp_pix++;
                    total_grp++;
                    chk("acc_clr", acc_clr, int'(exp_kg == 0));
                end else begin
                    chk("acc_clr_hold", acc_clr, 0);
                end
                chk("k_grp", k_grp, exp_kg);
                chk("acc_last", acc_last, int'(exp_kg == ngrp_m - 1));
                gap_len = 0;
            end else begin
                gap_len++;
            end
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    chk("res_n", n, sb[0].n);
                    chk("res_i", patch_i, sb[0].i);
                    chk("res_j", patch_j, sb[0].j);
                end
                if (!res_ready) stall_seen++;
                if (res_ready) begin
                    chk("groups_per_pix", grp_pix, ngrp_m);
                    grp_pix = 0;
                    if (sb.size() != 0) void'(sb.pop_front());
                    accepted++;
                    pix_new = 1'b1;
                end
            end
            prev_en = en_im2;
        end
    end

    task automatic setup(input vec_t t);
        sb.delete();
        if (t.err == 0)
            for (int a = 0; a < t.nout; a++)
                for (int b = 0; b < t.oh; b++)
                    for (int c = 0; c < t.ow; c++)
                        sb.push_back('{a, b, c});
        ngrp_m     = t.ngrp;
        pix_new    = 1'b1;
        gap_len    = 0;
        grp_pix    = 0;
        total_grp  = 0;
        accepted   = 0;
        done_cnt   = 0;
        busy_cnt   = 0;
        stall_at   = t.stall_at;
        stall_left = 5;
        stall_seen = 0;
        @(negedge clk);
        X1     = X1W'(t.x1);
        X2     = X2W'(t.x2);
        X3     = X3W'(t.x3);
        Y1     = Y1W'(t.y1);
        Y2     = Y2W'(t.y2);
        STRIDE = 3'(t.s);
        N_OUT  = NW'(t.nout);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic run_vec(input vec_t t);
        int cyc;
        int exp_stall;
        setup(t);
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
        chk("busy_in_fin", busy, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("err", err, t.err);
        chk("sb_left", sb.size(), 0);
        chk("total_groups", total_grp, t.nout * t.ow * t.oh * t.ngrp);
        chk("done_pulses", done_cnt, 1);
        exp_stall = (t.stall_at >= 0) ? 5 : 0;
        chk("stall_cycles", stall_seen, exp_stall);
`ifdef CNN_SCHED_PERF_EN
        chk("perf_stall", int'(perf_stall), exp_stall);
        chk("perf_cycles", int'(perf_cycles), busy_cnt);
`endif
    endtask

    initial begin
        vec_t v[7];
        vec_t r;
        int   cyc;
        v[0] = '{3, 3, 1,  5,  5, 1, 1,  3,  3, 1, 0,  2};
        v[1] = '{5, 5, 3,  5,  5, 1, 2,  1,  1, 3, 0, -1};
        v[2] = '{5, 5, 1, 32, 32, 2, 1, 14, 14, 1, 0, -1};
        v[3] = '{5, 5, 1,  5,  5, 0, 1,  0,  0, 1, 1, -1};
        v[4] = '{5, 5, 1,  3,  5, 1, 1,  0,  0, 1, 1, -1};
        v[5] = '{3, 3, 1,  5,  5, 1, 0,  0,  0, 1, 1, -1};
        v[6] = '{2, 3, 32, 9,  7, 3, 3,  3,  2, 6, 0,  4};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_en_im2", en_im2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_k_grp", k_grp, 0);
        chk("rst_n", n, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(v[i]);

        r = v[0];
        r.stall_at = -1;
        setup(r);
        cyc = 0;
        while (!(accepted == 4 && en_im2) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_pixel4", int'(accepted == 4 && en_im2), 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_en_im2", en_im2, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_acc_clr", acc_clr, 0);
        chk("midrst_acc_last", acc_last, 0);
        chk("midrst_patch_i", patch_i, 0);
        chk("midrst_patch_j", patch_j, 0);
        chk("midrst_res_valid", res_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(r);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_tile_sched.md
# conv_tile_sched

Loop-nest scheduler sitting directly upstream of the im2col address generator in the DA CNN datapath. On a start pulse it derives output feature-map dimensions and K-group count from the layer configuration. It then walks output channel, patch row, patch column and K-group, driving the generator's enable and index inputs one group at a time. It also frames accumulation for the downstream MAC and hands each finished output pixel to writeback through a valid/ready handshake.

## Interface
- CHUNK_K, 8, K-steps per group; CHUNK_K*PACK must be a power of two
- PACK, 4, elements per K-step
- MAX_X1 / MAX_X2 / MAX_X3, 5 / 5 / 32, kernel width / height / depth bounds
- MAX_Y1 / MAX_Y2, 32 / 32, map width / height bounds
- MAX_N, 64, output-channel bound
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  launch pulse; ignored while busy
- X1, X2, X3, Y1, Y2  in  $clog2(MAX_*)+1 each  layer geometry, sampled on start
- N_OUT  in  $clog2(MAX_N)+1  output channel count, sampled on start
- STRIDE  in  3  stride, sampled on start
- im2_done  in  1  generator finished current group
- en_im2  out  1  generator enable
- patch_i, patch_j  out  $clog2(MAX_Y2)+1, $clog2(MAX_Y1)+1  output row / column
- n, k_grp  out  16, 16  output channel, K-group
- acc_clr  out  1  one-cycle pulse: first RUN cycle of k_grp 0
- acc_last  out  1  level during RUN of final K-group
- res_valid  out  1  pixel result ready for writeback
- res_ready  in  1  writeback accepts
- busy, done, err  out  1 each  running / end-of-layer pulse / config error (sticky until next start)

## Operation
- States: IDLE, CALC, RUN, GAP, RES, FIN.
- IDLE: start=1 latches config and clears err.
  - STRIDE=0, Y1<X1, Y2<X2 or N_OUT=0 -> FIN with err=1, zero groups issued.
  - Otherwise -> CALC.
- CALC: conv_dim_calc computes OW=(Y1-X1)/STRIDE+1 and OH=(Y2-X2)/STRIDE+1 by parallel repeated subtraction.
  - NGRP = ceil(X1*X2*X3 / (CHUNK_K*PACK)), computed by shift and round-up.
  - Leaves CALC the cycle after both divisions complete; all indices are 0.
- RUN: en_im2=1, indices held stable. When im2_done is sampled high -> GAP.
- GAP: en_im2=0 for exactly one cycle, which lets the generator clear its counter.
  - If k_grp<NGRP-1: k_grp++ and -> RUN.
  - Otherwise -> RES.
- RES: res_valid=1 with n/patch_i/patch_j stable. On res_valid&&res_ready, advance the loop nest in order k_grp (reset to 0) -> patch_j -> patch_i -> n, then -> RUN.
  - If the final pixel of the final channel was accepted -> FIN.
- FIN: done=1 for one cycle, then -> IDLE.
- Loop nest wrap: patch_j wraps at OW-1, patch_i at OH-1, n at N_OUT-1.
- Arithmetic: X1*X2*X3 is formed at 16 bits. OW/OH are bounded by MAX_Y; no overflow is possible within the parameter bounds.

## Timing
- Reset values: all outputs 0; state IDLE.
- start -> busy=1 on the next cycle. busy stays high through FIN and drops the cycle after done.
- en_im2 rises one cycle after CALC exits.
- Per group: RUN length is set by im2_done, followed by one GAP cycle.
- RES costs one cycle minimum plus backpressure stall cycles.
- acc_clr coincides with the first en_im2=1 cycle of every pixel.
- acc_last is asserted for all RUN cycles of group NGRP-1. With NGRP=1 it coincides with acc_clr.
- im2_done high outside RUN is ignored. start during busy is ignored.
- rst mid-operation: outputs clear immediately and the FSM returns to IDLE. No done is generated.

## Configuration
- CNN_SCHED_PERF_EN defined: adds 32-bit outputs perf_cycles (cycles with busy=1) and perf_stall (RES cycles with res_ready=0). Both clear on start and on rst.
- CNN_SCHED_PERF_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package cnn_sched_pkg: state enum, index width localparams, GRP_ELEMS=CHUNK_K*PACK and its log2.
- Sub-module conv_dim_calc: one instance per dimension; sequential subtract-loop divider with start/ready.

## Test plan
- X1=X2=3, X3=1, Y1=Y2=5, STRIDE=1, N_OUT=1 -> NGRP=1. Nine results (0,0),(0,1)…(2,2); acc_clr and acc_last both high on each pixel's first RUN cycle; one done pulse.
- X1=X2=5, X3=3, Y=5, STRIDE=1, N_OUT=2 -> 75 elements, NGRP=3. k_grp sequence 0,1,2 per pixel; two results (n=0, n=1); one GAP cycle between RUN bursts.
- X=5, Y=32, STRIDE=2, N_OUT=1 -> OW=OH=14 and 196 results; last result is (13,13).
- res_ready held low for 5 cycles on the third result -> res_valid and indices stable, no en_im2 during the stall. With CNN_SCHED_PERF_EN, perf_stall=5.
- STRIDE=0, or Y1=3 with X1=5 -> err=1, done pulse, en_im2 never asserted.
- rst asserted during RUN of pixel 4 -> outputs 0 next edge. A following start runs cleanly from (0,0,0).
